// File: rtl/eth_tx_mac_framer_if.sv
// eth_tx_mac_framer_if: config, payload stream and GMII-side signals of the TX framer
interface eth_tx_mac_framer_if;
  logic        i_start;
  logic [47:0] i_dst_mac;
  logic [47:0] i_src_mac;
  logic [15:0] i_ethertype;
  logic [15:0] i_vlan_tci;
  logic [7:0]  i_gap_count;
  logic [7:0]  i_pay_data;
  logic        i_pay_valid;
  logic        i_pay_last;
  logic        o_pay_ready;
  logic [7:0]  o_tx_data;
  logic        o_tx_en;
  logic        o_tx_er;
  logic        o_busy;
  logic        o_frame_done;
  logic        o_underflow;
  logic        o_truncated;
  modport master (
    output i_start, i_dst_mac, i_src_mac, i_ethertype, i_vlan_tci, i_gap_count,
           i_pay_data, i_pay_valid, i_pay_last,
    input  o_pay_ready, o_tx_data, o_tx_en, o_tx_er, o_busy, o_frame_done, o_underflow, o_truncated
  );
  modport slave (
    input  i_start, i_dst_mac, i_src_mac, i_ethertype, i_vlan_tci, i_gap_count,
           i_pay_data, i_pay_valid, i_pay_last,
    output o_pay_ready, o_tx_data, o_tx_en, o_tx_er, o_busy, o_frame_done, o_underflow, o_truncated
  );
endinterface

// File: rtl/eth_tx_mac_framer.sv
// eth_tx_mac_framer: GMII-style Ethernet TX framer with padding, FCS and IFG.
// Define ETH_TX_VLAN_EN to insert an 802.1Q tag after the source MAC.
module eth_tx_mac_framer #(
  parameter int PREAMBLE_LEN = 7,
  parameter int MIN_PAYLOAD  = 46,
  parameter int MAX_PAYLOAD  = 1500,
  parameter int IFG_MIN      = 12
) (
  input logic i_eth_clk,
  input logic i_rst,
  eth_tx_mac_framer_if.slave bus
);
`ifdef ETH_TX_VLAN_EN
  localparam int HDR_W   = 144;
  localparam int PAD_TGT = MIN_PAYLOAD - 4;
`else
  localparam int HDR_W   = 112;
  localparam int PAD_TGT = MIN_PAYLOAD;
  logic unused_tci;
  assign unused_tci = ^bus.i_vlan_tci;
`endif
  localparam logic [10:0] PRE_LAST = 11'(PREAMBLE_LEN - 1);
  localparam logic [10:0] PAD_LAST = 11'(PAD_TGT - 1);
  localparam logic [10:0] MAX_LAST = 11'(MAX_PAYLOAD - 1);
  localparam logic [7:0]  IFG_MIN8 = 8'(IFG_MIN);
  typedef enum logic [3:0] {
    S_IDLE, S_PRE, S_SFD, S_DST, S_SRC,
`ifdef ETH_TX_VLAN_EN
    S_VLAN,
`endif
    S_TYPE, S_PAYLOAD, S_PAD, S_FCS, S_IFG
  } state_t;
  state_t state_q, state_d;
  logic [10:0] cnt_q, cnt_d;
  logic [HDR_W-1:0] hdr_q, hdr_d;
  logic [31:0] crc_q, crc_d;
  logic [7:0] gap_q, gap_d, tx_data_q, tx_data_d;
  logic busy_q, busy_d, tx_en_q, tx_en_d, tx_er_q, tx_er_d;
  logic done_q, done_d, unf_q, unf_d, trunc_q, trunc_d;
  function automatic logic [31:0] crc8(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
    return r;
  endfunction
  always_ff @(posedge i_eth_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hdr_q     <= '0;
      crc_q     <= '1;
      gap_q     <= '0;
      tx_data_q <= '0;
      busy_q    <= 1'b0;
      tx_en_q   <= 1'b0;
      tx_er_q   <= 1'b0;
      done_q    <= 1'b0;
      unf_q     <= 1'b0;
      trunc_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hdr_q     <= hdr_d;
      crc_q     <= crc_d;
      gap_q     <= gap_d;
      tx_data_q <= tx_data_d;
      busy_q    <= busy_d;
      tx_en_q   <= tx_en_d;
      tx_er_q   <= tx_er_d;
      done_q    <= done_d;
      unf_q     <= unf_d;
      trunc_q   <= trunc_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 11'd1;
    case (state_q)
      S_IDLE:    state_d = bus.i_start ? S_PRE : S_IDLE;
      S_PRE:     state_d = cnt_q == PRE_LAST ? S_SFD : S_PRE;
      S_SFD:     state_d = S_DST;
      S_DST:     state_d = cnt_q == 11'd5 ? S_SRC : S_DST;
`ifdef ETH_TX_VLAN_EN
      S_SRC:     state_d = cnt_q == 11'd5 ? S_VLAN : S_SRC;
      S_VLAN:    state_d = cnt_q == 11'd3 ? S_TYPE : S_VLAN;
`else
      S_SRC:     state_d = cnt_q == 11'd5 ? S_TYPE : S_SRC;
`endif
      S_TYPE:    state_d = cnt_q == 11'd1 ? S_PAYLOAD : S_TYPE;
      S_PAYLOAD: state_d = !bus.i_pay_valid ? S_IFG :
                           bus.i_pay_last ? (cnt_q < PAD_LAST ? S_PAD : S_FCS) :
                           cnt_q == MAX_LAST ? S_FCS : S_PAYLOAD;
      S_PAD:     state_d = cnt_q == PAD_LAST ? S_FCS : S_PAD;
      S_FCS:     state_d = cnt_q == 11'd3 ? S_IFG : S_FCS;
      S_IFG:     state_d = cnt_q == {3'b000, gap_q - 8'd1} ? S_IDLE : S_IFG;
      default:   state_d = S_IDLE;
    endcase
    // the payload count carries into PAD so padding stops at the target size
    if ((state_d != state_q && state_d != S_PAD) || state_q == S_IDLE) cnt_d = '0;
  end
  always_comb begin
    logic upd;
    upd       = 1'b0;
    tx_data_d = 8'h00;
    tx_en_d   = !(state_q inside {S_IDLE, S_IFG});
    tx_er_d   = 1'b0;
    done_d    = 1'b0;
    unf_d     = 1'b0;
    trunc_d   = 1'b0;
    hdr_d     = hdr_q;
    crc_d     = crc_q;
    gap_d     = gap_q;
    busy_d    = state_d != S_IDLE;
    case (state_q)
      S_IDLE: begin
`ifdef ETH_TX_VLAN_EN
        hdr_d = {bus.i_dst_mac, bus.i_src_mac, 16'h8100, bus.i_vlan_tci, bus.i_ethertype};
`else
        hdr_d = {bus.i_dst_mac, bus.i_src_mac, bus.i_ethertype};
`endif
        gap_d = bus.i_gap_count < IFG_MIN8 ? IFG_MIN8 : bus.i_gap_count;
        crc_d = '1;
      end
      S_PRE: tx_data_d = 8'h55;
      S_SFD: tx_data_d = 8'hD5;
      S_PAYLOAD: begin
        tx_data_d = bus.i_pay_valid ? bus.i_pay_data : 8'h00;
        tx_er_d   = !bus.i_pay_valid;
        unf_d     = !bus.i_pay_valid;
        trunc_d   = bus.i_pay_valid && !bus.i_pay_last && cnt_q == MAX_LAST;
        upd       = bus.i_pay_valid;
      end
      S_PAD: upd = 1'b1;
      S_FCS: begin
        tx_data_d = ~crc_q[7:0];
        crc_d     = {8'h00, crc_q[31:8]};
        done_d    = cnt_q == 11'd3;
      end
      S_IFG: tx_data_d = 8'h00;
      default: begin
        tx_data_d = hdr_q[HDR_W-1 -: 8];
        hdr_d     = hdr_q << 8;
        upd       = 1'b1;
      end
    endcase
    if (upd) crc_d = crc8(crc_q, tx_data_d);
  end
  assign bus.o_pay_ready  = state_q == S_PAYLOAD;
  assign bus.o_tx_data    = tx_data_q;
  assign bus.o_tx_en      = tx_en_q;
  assign bus.o_tx_er      = tx_er_q;
  assign bus.o_busy       = busy_q;
  assign bus.o_frame_done = done_q;
  assign bus.o_underflow  = unf_q;
  assign bus.o_truncated  = trunc_q;
endmodule

// File: tb/tb_eth_tx_mac_framer.sv
// tb_eth_tx_mac_framer: scoreboard bench; a frame-level reference model queues expected bytes,
// a monitor pops and compares every byte the framer transmits.
module tb_eth_tx_mac_framer;
  typedef logic [7:0] u8;
  typedef struct packed { logic [7:0] d; logic er, dn, uf, tr; } exp_t;
  localparam int MAXP = 1500;
`ifdef ETH_TX_VLAN_EN
  localparam int PADT = 42;
`else
  localparam int PADT = 46;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  eth_tx_mac_framer_if bus();
  eth_tx_mac_framer dut (.i_eth_clk(clk), .i_rst(rst), .bus(bus));
  always #4 clk = ~clk;

  exp_t exp_q[$];
  u8    src_d[$];
  logic src_l[$];
  int checks = 0, errors = 0;
  int hole_cnt = -1, pops = 0;
  int on_run = 0, off_run = 0, last_on = 0, last_off = 0;
  int done_cnt = 0, unf_cnt = 0, trunc_cnt = 0;
  bit pend = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic logic [31:0] fcs32(input u8 b[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (b[i])
      for (int k = 0; k < 8; k++)
        c = (c[0] ^ b[i][k]) ? (c >> 1) ^ 32'hEDB88320 : c >> 1;
    return ~c;
  endfunction

  // payload source: one-byte lookahead, transfer committed when valid&ready seen before the edge
  initial begin
    bit hole_now;
    bus.i_pay_valid = 1'b0;
    bus.i_pay_data  = 8'h00;
    bus.i_pay_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (pend && !rst && src_d.size() > 0) begin
        src_d.delete(0);
        src_l.delete(0);
        pops++;
        if (hole_cnt > 0) hole_cnt--;
      end
      hole_now = hole_cnt == 0 && bus.o_pay_ready;
      if (hole_now) hole_cnt = -1;
      bus.i_pay_valid = src_d.size() > 0 && !hole_now;
      bus.i_pay_data  = src_d.size() > 0 ? src_d[0] : 8'h00;
      bus.i_pay_last  = src_d.size() > 0 && src_l[0];
      pend = bus.i_pay_valid && bus.o_pay_ready && !rst;
    end
  end

  // monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        on_run = 0;
        off_run = 0;
      end else if (bus.o_tx_en) begin
        if (off_run > 0) last_off = off_run;
        off_run = 0;
        on_run++;
        if (bus.o_frame_done) done_cnt++;
        if (bus.o_underflow) unf_cnt++;
        if (bus.o_truncated) trunc_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_byte actual=%0h required=none", bus.o_tx_data);
        end else begin
          e = exp_q.pop_front();
          chk("tx_byte", {bus.o_tx_data, bus.o_tx_er, bus.o_frame_done, bus.o_underflow, bus.o_truncated}, e);
        end
      end else begin
        if (on_run > 0) last_on = on_run;
        on_run = 0;
        off_run++;
        chk("idle_flags", {bus.o_tx_er, bus.o_frame_done, bus.o_underflow, bus.o_truncated}, 4'b0000);
      end
    end
  end

  // reference model: queue the whole expected frame and its payload source bytes
  task automatic prep(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t, input logic [15:0] v,
                      input u8 g, input int n, input int first, input int hole, output int len);
    u8 pay[$];
    u8 body[$];
    int np;
    bit tr;
    logic [31:0] f;
    bus.i_dst_mac = d;
    bus.i_src_mac = s;
    bus.i_ethertype = t;
    bus.i_vlan_tci = v;
    bus.i_gap_count = g;
    for (int i = 0; i < n; i++) begin
      pay.push_back(first < 0 ? u8'($urandom) : u8'(first + i));
      src_d.push_back(pay[i]);
      src_l.push_back(i == n - 1);
    end
    hole_cnt = hole;
    for (int i = 0; i < 7; i++) exp_q.push_back({8'h55, 4'b0000});
    exp_q.push_back({8'hD5, 4'b0000});
    for (int i = 5; i >= 0; i--) body.push_back(d[8*i +: 8]);
    for (int i = 5; i >= 0; i--) body.push_back(s[8*i +: 8]);
`ifdef ETH_TX_VLAN_EN
    body.push_back(8'h81);
    body.push_back(8'h00);
    body.push_back(v[15:8]);
    body.push_back(v[7:0]);
`endif
    body.push_back(t[15:8]);
    body.push_back(t[7:0]);
    foreach (body[i]) exp_q.push_back({body[i], 4'b0000});
    np = hole >= 0 ? hole : (n > MAXP ? MAXP : n);
    tr = hole < 0 && n > MAXP;
    for (int i = 0; i < np; i++) begin
      body.push_back(pay[i]);
      exp_q.push_back({pay[i], 3'b000, tr && i == MAXP - 1});
    end
    if (hole >= 0) begin
      exp_q.push_back({8'h00, 4'b1010});
      len = 8 + body.size() + 1;
    end else begin
      for (int i = np; i < PADT; i++) begin
        body.push_back(8'h00);
        exp_q.push_back({8'h00, 4'b0000});
      end
      f = fcs32(body);
      for (int k = 0; k < 4; k++) exp_q.push_back({f[8*k +: 8], 1'b0, k == 3, 2'b00});
      len = 8 + body.size() + 4;
    end
  endtask

  task automatic go();
    int t;
    @(negedge clk);
    bus.i_start = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.o_busy && t < 20);
    chk("start_busy", bus.o_busy, 1'b1);
    bus.i_start = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || bus.o_busy) && t < 4000) begin
      @(negedge clk);
      t++;
    end
    chk("frame_complete", {exp_q.size() == 0, bus.o_busy}, 2'b10);
  endtask

  task automatic flush_src();
    src_d.delete();
    src_l.delete();
    hole_cnt = -1;
  endtask

  task automatic b2b(input u8 g);
    int l1, l2, t, d0, gap;
    gap = g < 12 ? 12 : int'(g);
    prep(48'h0A0B0C0D0E0F, 48'h112233445566, 16'h88B5, 16'h0001, g, 5, -1, -1, l1);
    prep(48'h0A0B0C0D0E0F, 48'h112233445566, 16'h88B5, 16'h0001, g, 50, -1, -1, l2);
    d0 = done_cnt;
    @(negedge clk);
    bus.i_start = 1'b1;
    t = 0;
    while (done_cnt == d0 && t < 200) begin @(negedge clk); t++; end
    while (bus.o_busy && t < 500) begin @(negedge clk); t++; end
    while (!bus.o_busy && t < 510) begin @(negedge clk); t++; end
    bus.i_start = 1'b0;
    chk("b2b_restart", bus.o_busy, 1'b1);
    wait_idle();
    chk("b2b_gap", last_off, gap + 1);
    chk("b2b_len2", last_on, l2);
    chk("b2b_done", done_cnt - d0, 2);
  endtask

  initial begin
    int len, d0, u0, t0, p0;
    bus.i_start = 1'b0;
    bus.i_dst_mac = '0;
    bus.i_src_mac = '0;
    bus.i_ethertype = '0;
    bus.i_vlan_tci = '0;
    bus.i_gap_count = '0;
    repeat (2) @(negedge clk);
    chk("rst_out", {bus.o_tx_data, bus.o_tx_en, bus.o_tx_er, bus.o_busy, bus.o_pay_ready,
                    bus.o_frame_done, bus.o_underflow, bus.o_truncated}, 15'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_tx_en", bus.o_tx_en, 1'b0);
    chk("idle_busy", bus.o_busy, 1'b0);

    d0 = done_cnt;
    prep(48'hFFFFFFFFFFFF, 48'h1A2B3C4D5E6F, 16'h0800, 16'h0064, 8'd12, 10, 1, -1, len);
    go();
    wait_idle();
    chk("short_len", last_on, len);
    chk("short_len72", last_on, 72);
    chk("short_done", done_cnt - d0, 1);

    d0 = done_cnt;
    prep(48'h00AA00BB00CC, 48'h1A2B3C4D5E6F, 16'h0806, 16'h0064, 8'd12, 46, 0, -1, len);
    go();
    wait_idle();
    chk("min_len72", last_on, 72);
    chk("min_done", done_cnt - d0, 1);

    for (int r = 0; r < 6; r++) begin
      d0 = done_cnt;
      prep({16'($urandom), $urandom}, {16'($urandom), $urandom}, 16'($urandom), 16'($urandom),
           u8'($urandom_range(0, 30)), $urandom_range(1, 120), -1, -1, len);
      go();
      wait_idle();
      chk("rand_len", last_on, len);
      chk("rand_done", done_cnt - d0, 1);
    end

    d0 = done_cnt;
    u0 = unf_cnt;
    prep(48'h010203040506, 48'h0708090A0B0C, 16'h86DD, 16'h0064, 8'd12, 60, -1, 20, len);
    go();
    wait_idle();
    flush_src();
    chk("starve_len", last_on, len);
    chk("starve_unf", unf_cnt - u0, 1);
    chk("starve_no_fcs", done_cnt - d0, 0);

    b2b(8'd3);
    b2b(8'd20);

    prep(48'h222222222222, 48'h333333333333, 16'h0800, 16'h0064, 8'd12, 60, -1, -1, len);
    go();
    p0 = pops;
    t0 = 0;
    while (pops - p0 < 30 && t0 < 200) begin @(negedge clk); t0++; end
    chk("rst_mid_reached", pops - p0 >= 30, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_tx_en", bus.o_tx_en, 1'b0);
    chk("rst_mid_busy", bus.o_busy, 1'b0);
    exp_q.delete();
    flush_src();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    d0 = done_cnt;
    prep(48'h444444444444, 48'h555555555555, 16'h0800, 16'h0064, 8'd12, 30, 5, -1, len);
    go();
    wait_idle();
    chk("post_rst_len", last_on, len);
    chk("post_rst_done", done_cnt - d0, 1);

    d0 = done_cnt;
    t0 = trunc_cnt;
    prep(48'h666666666666, 48'h777777777777, 16'h0800, 16'h0064, 8'd12, MAXP + 1, -1, -1, len);
    go();
    wait_idle();
    flush_src();
    chk("trunc_len", last_on, len);
    chk("trunc_pulse", trunc_cnt - t0, 1);
    chk("trunc_done", done_cnt - d0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
endmodule
